// File: rtl/seg7_scan_drv_pkg.sv
// Purpose : shared 7-segment pattern constants and code-to-pattern helper.
// Latency : n/a (constants and a pure function).
// Backpres: n/a.
// Segment bit order everywhere is {g,f,e,d,c,b,a}, active-high.
package seg7_scan_drv_pkg;

  localparam logic [6:0] SEG7_0     = 7'b0111111;
  localparam logic [6:0] SEG7_1     = 7'b0000110;
  localparam logic [6:0] SEG7_2     = 7'b1011011;
  localparam logic [6:0] SEG7_3     = 7'b1001111;
  localparam logic [6:0] SEG7_4     = 7'b1100110;
  localparam logic [6:0] SEG7_5     = 7'b1101101;
  localparam logic [6:0] SEG7_6     = 7'b1111101;
  localparam logic [6:0] SEG7_7     = 7'b0000111;
  localparam logic [6:0] SEG7_8     = 7'b1111111;
  localparam logic [6:0] SEG7_9     = 7'b1101111;
  localparam logic [6:0] SEG7_DASH  = 7'b1000000;
  localparam logic [6:0] SEG7_BLANK = 7'b0000000;

  // Non-BCD codes (10..15) show a dash so a corrupted counter is visible.
  function automatic logic [6:0] seg7_pattern(input logic [3:0] code);
    case (code)
      4'd0:    return SEG7_0;
      4'd1:    return SEG7_1;
      4'd2:    return SEG7_2;
      4'd3:    return SEG7_3;
      4'd4:    return SEG7_4;
      4'd5:    return SEG7_5;
      4'd6:    return SEG7_6;
      4'd7:    return SEG7_7;
      4'd8:    return SEG7_8;
      4'd9:    return SEG7_9;
      default: return SEG7_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_drv_decode.sv
// Purpose : combinational BCD digit + blank request -> 7 active-high segments.
// Latency : 0 cycles (pure combinational).
// Backpres: none.
// Ports   : code[3:0] digit code, blank forces all segments off, seg[6:0] = {g,f,e,d,c,b,a}.
module seg7_decode
  import seg7_scan_drv_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG7_BLANK;
    if (!blank) seg = seg7_pattern(code);
  end

endmodule

// File: rtl/seg7_scan_drv.sv
// Purpose : time-multiplexed N-digit 7-segment driver with frame-wise BCD snapshot.
// Latency : outputs registered, 1 CLK after scan index / snapshot change.
// Backpres: none; CE=0 freezes prescaler, index and snapshot (outputs hold).
// Ports   : CLK, CLR (async active-high), CE, BCD[4*DIGITS-1:0], DP[DIGITS-1:0], BLANK_LZ,
//           SEG[6:0] {g,f,e,d,c,b,a}, DP_OUT, AN[DIGITS-1:0] one-hot; polarity set by ACTIVE_LOW.
module seg7_scan_drv
  import seg7_scan_drv_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  CE,
  input  logic [4*DIGITS-1:0]   BCD,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  BLANK_LZ,
  output logic [6:0]            SEG,
  output logic                  DP_OUT,
  output logic [DIGITS-1:0]     AN
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(DIGITS);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] snap_bcd;
  logic [DIGITS-1:0]   snap_dp;
  logic                tick;
  logic                frame_wrap;

  assign tick       = CE && (cnt == CNT_W'(PRESCALE - 1));
  assign frame_wrap = tick && (idx == IDX_W'(DIGITS - 1));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt      <= '0;
      idx      <= '0;
      snap_bcd <= '0;
      snap_dp  <= '0;
    end else begin
      if (CE) cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) idx <= frame_wrap ? '0 : idx + IDX_W'(1);
      // Sampling only at the frame wrap keeps a whole frame consistent.
      if (frame_wrap) begin
        snap_bcd <= BCD;
        snap_dp  <= DP;
      end
    end
  end

  // lead_zero[i]: snapshot digits DIGITS-1..i are all zero; bit 0 stays 0
  // so the least significant digit is never blanked.
  logic [DIGITS-1:0] lead_zero;

  always_comb begin : lz_scan
    logic all_zero;
    lead_zero = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero     = all_zero && (snap_bcd[4*i +: 4] == 4'd0);
      lead_zero[i] = all_zero;
    end
  end

  logic [3:0]        cur_code;
  logic              cur_blank;
  logic [6:0]        seg_dec;
  logic [DIGITS-1:0] an_dec;

  assign cur_code  = snap_bcd[{idx, 2'b00} +: 4];
  assign cur_blank = BLANK_LZ && lead_zero[idx];
  assign an_dec    = DIGITS'(1) << idx;

  seg7_decode u_decode (
    .code  (cur_code),
    .blank (cur_blank),
    .seg   (seg_dec)
  );

  // Output regs track the held state every cycle, so with CE=0 they hold.
  // Polarity is applied only here; everything upstream is active-high.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      SEG    <= {7{ACTIVE_LOW}};
      DP_OUT <= ACTIVE_LOW;
      AN     <= {DIGITS{ACTIVE_LOW}};
    end else begin
      SEG    <= seg_dec ^ {7{ACTIVE_LOW}};
      DP_OUT <= snap_dp[idx] ^ ACTIVE_LOW;
      AN     <= an_dec ^ {DIGITS{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_drv.sv
module tb_seg7_scan_drv;

  logic        clk = 1'b0;
  logic        clr;
  logic        ce;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [6:0]  seg, seg_l;
  logic        dp_out, dp_out_l;
  logic [3:0]  an, an_l;

  int total = 0;
  int bad   = 0;

  // Hand-written patterns {g,f,e,d,c,b,a}: 0..9 then dash for 10..15.
  logic [6:0] pat [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  always #5 clk = ~clk;

  seg7_scan_drv #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut (
    .CLK(clk), .CLR(clr), .CE(ce), .BCD(bcd), .DP(dp), .BLANK_LZ(blank_lz),
    .SEG(seg), .DP_OUT(dp_out), .AN(an)
  );

  seg7_scan_drv #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dut_l (
    .CLK(clk), .CLR(clr), .CE(ce), .BCD(bcd), .DP(dp), .BLANK_LZ(blank_lz),
    .SEG(seg_l), .DP_OUT(dp_out_l), .AN(an_l)
  );

  // Lands on the negedge of the first cycle of a frame (AN just went 1000 -> 0001).
  task automatic wait_frame(output bit ok);
    int n = 0;
    while (an !== 4'b1000 && n < 200) begin @(negedge clk); n++; end
    while (an !== 4'b0001 && n < 200) begin @(negedge clk); n++; end
    ok = (an === 4'b0001) && (n < 200);
  endtask

  task automatic test_reset();
    clr = 1'b1; ce = 1'b1; bcd = 16'h0000; dp = 4'b0000; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (seg !== 7'h00)      begin bad++; $display("FAIL reset_seg got=%h want=00", seg); end
    total++; if (dp_out !== 1'b0)    begin bad++; $display("FAIL reset_dp got=%b want=0", dp_out); end
    total++; if (an !== 4'b0000)     begin bad++; $display("FAIL reset_an got=%b want=0000", an); end
    total++; if (seg_l !== 7'h7F)    begin bad++; $display("FAIL reset_seg_l got=%h want=7f", seg_l); end
    total++; if (dp_out_l !== 1'b1)  begin bad++; $display("FAIL reset_dp_l got=%b want=1", dp_out_l); end
    total++; if (an_l !== 4'b1111)   begin bad++; $display("FAIL reset_an_l got=%b want=1111", an_l); end
    clr = 1'b0;
    @(negedge clk);
    total++; if (an !== 4'b0001)     begin bad++; $display("FAIL first_an got=%b want=0001", an); end
    total++; if (seg !== 7'h3F)      begin bad++; $display("FAIL first_seg got=%h want=3f", seg); end
    total++; if (an_l !== 4'b1110)   begin bad++; $display("FAIL first_an_l got=%b want=1110", an_l); end
  endtask

  task automatic test_scan();
    bit ok;
    logic [15:0] v = 16'h1234;
    logic [3:0]  nib;
    bcd = v;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL scan_frame_timeout an=%b", an); end
    for (int c = 0; c < 16; c++) begin
      nib = v[(c/4)*4 +: 4];
      total++; if (an !== (4'b0001 << (c/4))) begin bad++; $display("FAIL scan_an c=%0d got=%b want=%b", c, an, 4'b0001 << (c/4)); end
      total++; if (seg !== pat[nib]) begin bad++; $display("FAIL scan_seg c=%0d got=%b want=%b", c, seg, pat[nib]); end
      @(negedge clk);
    end
  endtask

  task automatic test_snapshot();
    bit ok;
    logic [15:0] v;
    logic [3:0]  nib;
    bcd = 16'h1234;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL snap_frame_timeout an=%b", an); end
    for (int c = 0; c < 24; c++) begin
      if (c == 6) bcd = 16'h5678;
      v   = (c < 16) ? 16'h1234 : 16'h5678;
      nib = v[((c/4)%4)*4 +: 4];
      total++; if (an !== (4'b0001 << ((c/4)%4))) begin bad++; $display("FAIL snap_an c=%0d got=%b want=%b", c, an, 4'b0001 << ((c/4)%4)); end
      total++; if (seg !== pat[nib]) begin bad++; $display("FAIL snap_seg c=%0d got=%b want=%b", c, seg, pat[nib]); end
      if (c == 16) begin
        total++; if (seg_l !== 7'h00)    begin bad++; $display("FAIL pol_seg8 got=%b want=0000000", seg_l); end
        total++; if (an_l !== 4'b1110)   begin bad++; $display("FAIL pol_an got=%b want=1110", an_l); end
        total++; if (dp_out_l !== 1'b1)  begin bad++; $display("FAIL pol_dp got=%b want=1", dp_out_l); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_leading_zero();
    bit ok;
    logic [6:0] exp_a [0:3] = '{7'h3F, 7'h07, 7'h00, 7'h00};
    bcd = 16'h0070; dp = 4'b0000; blank_lz = 1'b1;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL lz_frame_timeout an=%b", an); end
    for (int c = 0; c < 16; c++) begin
      total++; if (seg !== exp_a[c/4]) begin bad++; $display("FAIL lz70_seg c=%0d got=%b want=%b", c, seg, exp_a[c/4]); end
      @(negedge clk);
    end
    bcd = 16'h0000;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL lz0_frame_timeout an=%b", an); end
    for (int c = 0; c < 16; c++) begin
      total++; if (seg !== ((c < 4) ? 7'h3F : 7'h00)) begin bad++; $display("FAIL lz0_seg c=%0d got=%b", c, seg); end
      total++; if (an !== (4'b0001 << (c/4))) begin bad++; $display("FAIL lz0_an c=%0d got=%b want=%b", c, an, 4'b0001 << (c/4)); end
      @(negedge clk);
    end
    blank_lz = 1'b0;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL nolz_frame_timeout an=%b", an); end
    for (int c = 0; c < 16; c++) begin
      total++; if (seg !== 7'h3F) begin bad++; $display("FAIL nolz_seg c=%0d got=%b want=0111111", c, seg); end
      @(negedge clk);
    end
  endtask

  task automatic test_invalid_dp();
    bit ok;
    logic [6:0] exp_a [0:3] = '{7'h3F, 7'h40, 7'h00, 7'h00};
    bcd = 16'h00A0; dp = 4'b0100; blank_lz = 1'b1;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL inv_frame_timeout an=%b", an); end
    for (int c = 0; c < 16; c++) begin
      total++; if (seg !== exp_a[c/4]) begin bad++; $display("FAIL inv_seg c=%0d got=%b want=%b", c, seg, exp_a[c/4]); end
      total++; if (dp_out !== (c/4 == 2)) begin bad++; $display("FAIL inv_dp c=%0d got=%b want=%b", c, dp_out, (c/4 == 2)); end
      @(negedge clk);
    end
  endtask

  task automatic test_freeze();
    bit ok;
    int n = 0;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL frz_frame_timeout an=%b", an); end
    repeat (5) @(negedge clk);
    ce = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++; if (an !== 4'b0010) begin bad++; $display("FAIL frz_an c=%0d got=%b want=0010", c, an); end
      total++; if (seg !== 7'h40)  begin bad++; $display("FAIL frz_seg c=%0d got=%b want=1000000", c, seg); end
    end
    ce = 1'b1;
    while (an !== 4'b0100 && n < 12) begin @(negedge clk); n++; end
    total++; if (an !== 4'b0100) begin bad++; $display("FAIL frz_resume got=%b want=0100", an); end
  endtask

  task automatic test_clr_mid();
    repeat (3) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    total++; if (an !== 4'b0000)    begin bad++; $display("FAIL clrmid_an got=%b want=0000", an); end
    total++; if (seg !== 7'h00)     begin bad++; $display("FAIL clrmid_seg got=%b want=0000000", seg); end
    total++; if (dp_out !== 1'b0)   begin bad++; $display("FAIL clrmid_dp got=%b want=0", dp_out); end
    total++; if (an_l !== 4'b1111)  begin bad++; $display("FAIL clrmid_an_l got=%b want=1111", an_l); end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    total++; if (an !== 4'b0001)    begin bad++; $display("FAIL clrrel_an got=%b want=0001", an); end
    total++; if (seg !== 7'h3F)     begin bad++; $display("FAIL clrrel_seg got=%b want=0111111", seg); end
    total++; if (dp_out !== 1'b0)   begin bad++; $display("FAIL clrrel_dp got=%b want=0", dp_out); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_leading_zero();
    test_invalid_dp();
    test_freeze();
    test_clr_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
